// File: rtl/rst_wr_rd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_wr_rd_seq_pkg
// Purpose  : Shared types and constants for the reset/write/read sequencer.
//            Holds the FSM state encoding, the default parameter values and
//            the phase-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package rst_wr_rd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RST_PH = 2'd1,
    WIN    = 2'd2,
    FIN    = 2'd3
  } seq_state_e;

  localparam int          c_DEF_RST_CYCLES = 2;
  localparam int          c_DEF_WINDOW     = 10;
  localparam int          c_DEF_WR_OFFSET  = 3;
  localparam int          c_DEF_RD_OFFSET  = 7;
  localparam int          c_DEF_ADDR_W     = 4;
  localparam int          c_DEF_DATA_W     = 8;
  localparam logic [7:0]  c_DEF_DATA_SEED  = 8'hA5;

  // Width able to hold the larger of the two phase lengths as a value.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  localparam int CNT_W = cnt_width(c_DEF_RST_CYCLES, c_DEF_WINDOW);

endpackage
`default_nettype wire

// File: rtl/rst_wr_rd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rst_wr_rd_sequencer_if
// Purpose  : Bundle of the controller handshake and DUT pin signals.
//   start/bursts       : controller -> sequencer
//   busy/done/burst_idx: sequencer -> controller
//   dut_rst/wr/rd/addr/wdata : sequencer -> DUT under stimulus
//   master modport = sequencer side, slave modport = controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface rst_wr_rd_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic [7:0]        bursts;
  logic              busy;
  logic              done;
  logic [7:0]        burst_idx;
  logic              dut_rst;
  logic              dut_wr;
  logic              dut_rd;
  logic [ADDR_W-1:0] dut_addr;
  logic [DATA_W-1:0] dut_wdata;

  modport master (
    input  start, bursts,
    output busy, done, burst_idx, dut_rst, dut_wr, dut_rd, dut_addr, dut_wdata
  );

  modport slave (
    output start, bursts,
    input  busy, done, burst_idx, dut_rst, dut_wr, dut_rd, dut_addr, dut_wdata
  );
endinterface
`default_nettype wire

// File: rtl/rst_wr_rd_sequencer_seq_phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_phase_counter
// Purpose  : Clearable up-counter that wraps to 0 on a terminal count of
//            i_limit-1. Exposes its next value so the owner can register
//            outputs that line up with the counter register.
// Ports    : clk, rst      - clock / synchronous active-high reset
//            i_clr         - force count to 0 (priority over i_en)
//            i_en          - advance the count
//            i_limit       - run-time phase length (>= 1)
//            o_cnt_nxt     - value the counter will hold after this edge
//            o_tc          - current count is the last of the phase
// Revision : 1.0 - initial release
// ============================================================================
module seq_phase_counter #(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  input  wire logic [CNT_W-1:0] i_limit,
  output logic      [CNT_W-1:0] o_cnt_nxt,
  output logic                  o_tc
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tc;

  assign w_tc = (r_cnt == (i_limit - CNT_W'(1)));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      w_cnt_nxt = w_tc ? '0 : (r_cnt + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt_nxt = w_cnt_nxt;
  assign o_tc      = w_tc;
endmodule
`default_nettype wire

// File: rtl/rst_wr_rd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rst_wr_rd_sequencer
// Purpose  : Per burst, holds dut_rst high for RST_CYCLES clocks, then opens
//            a WINDOW-clock access phase with one write strobe at WR_OFFSET
//            and one read strobe at RD_OFFSET. Repeats for the latched burst
//            count and ends with a one-cycle done pulse.
// Ports    : clk, rst  - clock / synchronous active-high reset
//            seq_bus   - master side of rst_wr_rd_sequencer_if
// Revision : 1.0 - initial release
// ============================================================================
module rst_wr_rd_sequencer
  import rst_wr_rd_seq_pkg::*;
#(
  parameter int                RST_CYCLES = c_DEF_RST_CYCLES,
  parameter int                WINDOW     = c_DEF_WINDOW,
  parameter int                WR_OFFSET  = c_DEF_WR_OFFSET,
  parameter int                RD_OFFSET  = c_DEF_RD_OFFSET,
  parameter int                ADDR_W     = c_DEF_ADDR_W,
  parameter int                DATA_W     = c_DEF_DATA_W,
  parameter logic [DATA_W-1:0] DATA_SEED  = DATA_W'(c_DEF_DATA_SEED)
) (
  input wire logic              clk,
  input wire logic              rst,
  rst_wr_rd_sequencer_if.master seq_bus
);
  localparam int               c_CNT_W   = cnt_width(RST_CYCLES, WINDOW);
  localparam logic [c_CNT_W-1:0] c_RST_LIM = c_CNT_W'(RST_CYCLES);
  localparam logic [c_CNT_W-1:0] c_WIN_LIM = c_CNT_W'(WINDOW);
  localparam logic [c_CNT_W-1:0] c_WR_OFF  = c_CNT_W'(WR_OFFSET);
  localparam logic [c_CNT_W-1:0] c_RD_OFF  = c_CNT_W'(RD_OFFSET);

  if (RST_CYCLES < 1) begin : g_chk_rst_cycles
    $fatal(1, "rst_wr_rd_sequencer: RST_CYCLES must be >= 1");
  end
  if (WINDOW < 1) begin : g_chk_window
    $fatal(1, "rst_wr_rd_sequencer: WINDOW must be >= 1");
  end
  if (WR_OFFSET >= WINDOW) begin : g_chk_wr_offset
    $fatal(1, "rst_wr_rd_sequencer: WR_OFFSET must be < WINDOW");
  end
  if (RD_OFFSET >= WINDOW) begin : g_chk_rd_offset
    $fatal(1, "rst_wr_rd_sequencer: RD_OFFSET must be < WINDOW");
  end

  seq_state_e         r_state, w_state_nxt;
  logic [7:0]         r_bursts, w_bursts_nxt;
  logic [7:0]         r_idx, w_idx_nxt;
  logic               w_cnt_en, w_cnt_clr, w_tc;
  logic [c_CNT_W-1:0] w_limit, w_cnt_nxt;
  logic               w_last_burst;

  logic               w_busy_nxt, w_done_nxt, w_drst_nxt, w_wr_nxt, w_rd_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]  w_wdata_nxt;
  logic               r_busy, r_done, r_drst, r_wr, r_rd;
  logic [7:0]         r_idx_o;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;

  // The counter only runs in the two timed phases; it idles at zero so a
  // freshly accepted sequence always starts its reset phase at count 0.
  assign w_cnt_en  = (r_state == RST_PH) || (r_state == WIN);
  assign w_cnt_clr = !w_cnt_en;
  assign w_limit   = (r_state == RST_PH) ? c_RST_LIM : c_WIN_LIM;

  seq_phase_counter #(.CNT_W(c_CNT_W)) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .i_limit   (w_limit),
    .o_cnt_nxt (w_cnt_nxt),
    .o_tc      (w_tc)
  );

  assign w_last_burst = (r_idx == (r_bursts - 8'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bursts <= '0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bursts <= w_bursts_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_bursts_nxt = r_bursts;
    w_idx_nxt    = r_idx;
    unique case (r_state)
      IDLE: begin
        w_idx_nxt = '0;
        if (seq_bus.start) begin
          w_bursts_nxt = seq_bus.bursts;
          w_state_nxt  = (seq_bus.bursts != 8'd0) ? RST_PH : FIN;
        end
      end
      RST_PH: begin
        if (w_tc) w_state_nxt = WIN;
      end
      WIN: begin
        if (w_tc) begin
          if (w_last_burst) begin
            w_state_nxt = FIN;
          end else begin
            w_idx_nxt   = r_idx + 8'd1;
            w_state_nxt = RST_PH;
          end
        end
      end
      FIN: begin
        w_state_nxt  = IDLE;
        w_idx_nxt    = '0;
        w_bursts_nxt = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: decoded from the next state/count so every output is a
  // flop aligned with the state register rather than a decode of it.
  always_comb begin
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_done_nxt  = (w_state_nxt == FIN);
    w_drst_nxt  = (w_state_nxt == RST_PH);
    w_wr_nxt    = (w_state_nxt == WIN) && (w_cnt_nxt == c_WR_OFF);
    w_rd_nxt    = (w_state_nxt == WIN) && (w_cnt_nxt == c_RD_OFF);
    w_addr_nxt  = (w_wr_nxt || w_rd_nxt) ? ADDR_W'(w_idx_nxt) : '0;
    w_wdata_nxt = w_wr_nxt ? (DATA_SEED + DATA_W'(w_idx_nxt)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drst  <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_idx_o <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_drst  <= w_drst_nxt;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_idx_o <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign seq_bus.busy      = r_busy;
  assign seq_bus.done      = r_done;
  assign seq_bus.burst_idx = r_idx_o;
  assign seq_bus.dut_rst   = r_drst;
  assign seq_bus.dut_wr    = r_wr;
  assign seq_bus.dut_rd    = r_rd;
  assign seq_bus.dut_addr  = r_addr;
  assign seq_bus.dut_wdata = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_rst_wr_rd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_wr_rd_sequencer
// Purpose  : Directed self-checking bench for rst_wr_rd_sequencer. Two
//            instances: u_dut0 with default parameters and u_dut1 with
//            WINDOW=1, WR_OFFSET=RD_OFFSET=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_wr_rd_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  rst_wr_rd_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus0 ();
  rst_wr_rd_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus1 ();

  rst_wr_rd_sequencer u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .seq_bus (bus0)
  );

  rst_wr_rd_sequencer #(
    .WINDOW    (1),
    .WR_OFFSET (0),
    .RD_OFFSET (0)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .seq_bus (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, burst_idx[7:0], dut_rst, dut_wr, dut_rd, addr[3:0], wdata[7:0]}
  function automatic logic [24:0] obs(input bit which);
    if (which)
      return {bus1.busy, bus1.done, bus1.burst_idx, bus1.dut_rst, bus1.dut_wr,
              bus1.dut_rd, bus1.dut_addr, bus1.dut_wdata};
    return {bus0.busy, bus0.done, bus0.burst_idx, bus0.dut_rst, bus0.dut_wr,
            bus0.dut_rd, bus0.dut_addr, bus0.dut_wdata};
  endfunction

  // Expected outputs in cycle c (c=1 is the cycle after start is accepted).
  function automatic logic [24:0] exp_vec(input int n, input int rc, input int win,
                                          input int wo, input int ro, input int c);
    int         per, total, b, p;
    logic       e_rst, e_wr, e_rd;
    logic [7:0] e_idx, e_wd;
    logic [3:0] e_addr;
    per   = rc + win;
    total = n * per + 1;
    if (c > total) return '0;
    if (c == total) begin
      e_idx = (n == 0) ? 8'd0 : 8'(n - 1);
      return {1'b1, 1'b1, e_idx, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
    end
    b      = (c - 1) / per;
    p      = (c - 1) % per;
    e_rst  = (p < rc);
    e_wr   = !e_rst && ((p - rc) == wo);
    e_rd   = !e_rst && ((p - rc) == ro);
    e_idx  = 8'(b);
    e_addr = (e_wr || e_rd) ? 4'(b) : 4'h0;
    e_wd   = e_wr ? 8'(8'hA5 + b) : 8'h00;
    return {1'b1, 1'b0, e_idx, e_rst, e_wr, e_rd, e_addr, e_wd};
  endfunction

  task automatic check(input string tag, input int c, input logic [24:0] o,
                       input logic [24:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, o, e);
    end
  endtask

  task automatic drive(input bit which, input logic s, input logic [7:0] b);
    if (which) begin
      bus1.start = s; bus1.bursts = b;
    end else begin
      bus0.start = s; bus0.bursts = b;
    end
  endtask

  // Starts a run of n bursts and checks every cycle against the model.
  // spam: re-pulse start with bursts=9 while busy. abort_c: assert rst in
  // that cycle and check the sequence is cleanly aborted.
  task automatic run_seq(input bit which, input int n, input int rc, input int win,
                         input int wo, input int ro, input bit spam,
                         input int abort_c, input string tag);
    int total;
    total = n * (rc + win) + 1;
    drive(which, 1'b1, 8'(n));
    tick();
    for (int c = 1; c <= total + 1; c++) begin
      if (spam && (c <= total) && (c % 3 == 0)) drive(which, 1'b1, 8'd9);
      else                                      drive(which, 1'b0, 8'(n));
      check(tag, c, obs(which), exp_vec(n, rc, win, wo, ro, c));
      if (c == abort_c) begin
        rst = 1'b1;
        tick();
        check({tag, "_rst"}, c + 1, obs(which), '0);
        rst = 1'b0;
        for (int k = 2; k <= 5; k++) begin
          tick();
          check({tag, "_nodone"}, c + k, obs(which), '0);
        end
        return;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    tick();
    tick();
    check("reset0", 0, obs(1'b0), '0);
    check("reset1", 0, obs(1'b1), '0);
    rst = 1'b0;
    tick();
    check("idle0", 0, obs(1'b0), '0);

    run_seq(1'b0, 1, 2, 10, 3, 7, 1'b0, 0, "bursts1");
    run_seq(1'b0, 3, 2, 10, 3, 7, 1'b0, 0, "bursts3");
    run_seq(1'b0, 0, 2, 10, 3, 7, 1'b0, 0, "bursts0");
    // Burst 1 window, counter 5: cycle 12 + 2 + 5 + 1 = 20.
    run_seq(1'b0, 3, 2, 10, 3, 7, 1'b0, 20, "abort");
    run_seq(1'b0, 1, 2, 10, 3, 7, 1'b0, 0, "replay");
    run_seq(1'b0, 2, 2, 10, 3, 7, 1'b1, 0, "start_busy");
    run_seq(1'b1, 2, 2, 1, 0, 0, 1'b0, 0, "win1_same_off");
    run_seq(1'b0, 20, 2, 10, 3, 7, 1'b0, 0, "bursts20_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
